// File: rtl/hwag_coil_sched_pkg.sv
// hwag_pkg: shared angle-domain definitions for the hwag coil scheduler.
//   AW, ANGLE_MAX    : default angle width and last angle before wrap
//   angle_t          : engine angle type
//   angle_in_window  : wrap-aware test of whether target t lies in (last, cur]
package hwag_pkg;

  localparam int AW        = 13;
  localparam int ANGLE_MAX = 7679;

  typedef logic [AW-1:0] angle_t;

  // Angle moved from last to cur. Without a wrap the window is (last, cur].
  // Across a wrap it is (last, ANGLE_MAX] plus [0, cur]. No movement means
  // an empty window.
  function automatic logic angle_in_window(angle_t last, angle_t cur, angle_t t);
    logic hit;
    if (cur == last)     hit = 1'b0;
    else if (cur > last) hit = (t > last) && (t <= cur);
    else                 hit = (t > last) || (t <= cur);
    return hit;
  endfunction

endpackage

// File: rtl/hwag_coil_cfg_bank.sv
// hwag_coil_cfg_bank: double-buffered set/reset angle storage.
//   clk, rst         : clock, synchronous active-low reset
//   cfg_we/addr/data : write into the shadow bank, addr = {channel, sel}
//   cfg_commit       : arm a shadow->active transfer
//   wrap             : angle wrap seen this cycle; performs an armed transfer
//   commit_pend      : transfer armed, not yet done
//   act_set, act_rst : active angles used by the scheduler
module hwag_coil_cfg_bank #(
  parameter int CH = 4,
  parameter int AW = 13
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [$clog2(CH):0]        cfg_addr,
  input  logic [AW-1:0]              cfg_data,
  input  logic                       cfg_commit,
  input  logic                       wrap,
  output logic                       commit_pend,
  output logic [CH-1:0][AW-1:0]      act_set,
  output logic [CH-1:0][AW-1:0]      act_rst
);
  import hwag_pkg::*;

  localparam int CHW = $clog2(CH);

  logic [CH-1:0][AW-1:0] sh_set, sh_rst;
  logic [CHW-1:0]        wr_ch;

  assign wr_ch = cfg_addr[CHW:1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_set      <= '0;
      sh_rst      <= '0;
      act_set     <= '0;
      act_rst     <= '0;
      commit_pend <= 1'b0;
    end else begin
      if (cfg_we) begin
        if (cfg_addr[0]) sh_rst[wr_ch] <= cfg_data;
        else             sh_set[wr_ch] <= cfg_data;
      end
      // Both halves of every pair move on the same edge, and a write landing
      // on this edge is not part of the transfer (old shadow is copied).
      if (wrap && commit_pend) begin
        act_set <= sh_set;
        act_rst <= sh_rst;
      end
      // A commit arriving in a wrap cycle re-arms for the following wrap.
      if (cfg_commit) commit_pend <= 1'b1;
      else if (wrap)  commit_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/hwag_coil_sched.sv
// hwag_coil_sched: angle-domain ignition coil scheduler.
//   clk, rst        : clock, synchronous active-low reset
//   hwag_start      : angle valid; low forces coils off and resyncs tracking
//   angle           : engine angle 0..ANGLE_MAX, wraps to 0
//   ch_en           : per-channel enable (0 forces the coil off)
//   cfg_we/addr/data: shadow write, addr = {channel, sel(0=set,1=reset)}
//   cfg_commit      : shadow->active at the next wrap
//   commit_pend     : transfer outstanding
//   coil            : registered coil drive
//   overrun         : sticky, angle changed twice within one scan round
// One channel is evaluated per clock in round-robin order; each channel
// remembers the angle it last saw so events are detected as crossings.
module hwag_coil_sched #(
  parameter int CH        = 4,
  parameter int AW        = hwag_pkg::AW,
  parameter int ANGLE_MAX = hwag_pkg::ANGLE_MAX
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hwag_start,
  input  logic [AW-1:0]         angle,
  input  logic [CH-1:0]         ch_en,
  input  logic                  cfg_we,
  input  logic [$clog2(CH):0]   cfg_addr,
  input  logic [AW-1:0]         cfg_data,
  input  logic                  cfg_commit,
  output logic                  commit_pend,
  output logic [CH-1:0]         coil,
  output logic                  overrun
);
  import hwag_pkg::*;

  localparam int              CHW    = $clog2(CH);
  localparam logic [AW-1:0]   AMAX   = ANGLE_MAX[AW-1:0];
  localparam logic [AW:0]     PERIOD = ANGLE_MAX[AW:0] + 1'b1;

  logic [CHW-1:0]        slot, chg_slot;
  logic [AW-1:0]         ang_q;
  logic [CH-1:0][AW-1:0] last, act_set, act_rst;
  logic                  track;
  logic                  wrap, chg;

  logic [AW-1:0]         cur_last, t_set, t_rst;
  logic                  hit_set, hit_rst, coil_eval;
  logic [AW:0]           d_set, d_rst;

  // Forward angular distance from 'from' to 'to', going through the wrap.
  function automatic logic [AW:0] fwd_dist(input logic [AW-1:0] from, input logic [AW-1:0] to);
    return (to > from) ? ({1'b0, to} - {1'b0, from})
                       : ({1'b0, to} + PERIOD - {1'b0, from});
  endfunction

  assign wrap = hwag_start && (angle < ang_q);
  assign chg  = hwag_start && (angle != ang_q);

  hwag_coil_cfg_bank #(.CH(CH), .AW(AW)) u_bank (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cfg_commit  (cfg_commit),
    .wrap        (wrap),
    .commit_pend (commit_pend),
    .act_set     (act_set),
    .act_rst     (act_rst)
  );

  assign cur_last = last[slot];
  assign t_set    = act_set[slot];
  assign t_rst    = act_rst[slot];

  // Targets beyond the wheel range are storable but can never be crossed.
  assign hit_set = (t_set <= AMAX) && angle_in_window(cur_last, angle, t_set);
  assign hit_rst = (t_rst <= AMAX) && angle_in_window(cur_last, angle, t_rst);
  assign d_set   = fwd_dist(cur_last, t_set);
  assign d_rst   = fwd_dist(cur_last, t_rst);

  // When both events fall in one window the later one decides the final
  // level; equal angles give equal distances and so resolve to off.
  always_comb begin
    coil_eval = coil[slot];
    if (hit_set && hit_rst) coil_eval = (d_set > d_rst);
    else if (hit_set)       coil_eval = 1'b1;
    else if (hit_rst)       coil_eval = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot     <= '0;
      ang_q    <= '0;
      last     <= '0;
      coil     <= '0;
      overrun  <= 1'b0;
      track    <= 1'b0;
      chg_slot <= '0;
    end else begin
      slot  <= slot + 1'b1;
      ang_q <= angle;
      if (!hwag_start) begin
        // Resync every channel so re-start does not replay skipped angles.
        coil <= '0;
        last <= {CH{angle}};
      end else begin
        coil       <= coil & ch_en;
        coil[slot] <= coil_eval & ch_en[slot];
        last[slot] <= angle;
      end
      // A change arms tracking at the current slot; the round is complete
      // once the slot counter comes back to it. Another change before then
      // means some channel never saw the intermediate angle.
      if (chg) begin
        if (track && (slot != chg_slot)) overrun <= 1'b1;
        track    <= 1'b1;
        chg_slot <= slot;
      end else if (track && (slot == chg_slot)) begin
        track <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hwag_coil_sched.sv
module tb_hwag_coil_sched;
  localparam int CH   = 4;
  localparam int AW   = 13;
  localparam int AMAX = 7679;
  localparam int N    = AMAX + 1;
  localparam int STEP = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          hwag_start = 1'b0;
  logic [AW-1:0] angle = '0;
  logic [CH-1:0] ch_en = '1;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_addr = '0;
  logic [AW-1:0] cfg_data = '0;
  logic          cfg_commit = 1'b0;
  logic          commit_pend;
  logic [CH-1:0] coil;
  logic          overrun;

  hwag_coil_sched #(.CH(CH), .AW(AW), .ANGLE_MAX(AMAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .hwag_start  (hwag_start),
    .angle       (angle),
    .ch_en       (ch_en),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cfg_commit  (cfg_commit),
    .commit_pend (commit_pend),
    .coil        (coil),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;

  // Reference state: configuration banks, commit flag, expected coil levels.
  int          m_act_set[CH], m_act_rst[CH], m_sh_set[CH], m_sh_rst[CH];
  bit          m_pend;
  bit [CH-1:0] m_coil, m_en;
  int          cur;
  int          bslot = 0;

  // Scan position: restarts at 0 on reset, advances once per clock.
  always @(posedge clk) begin
    if (!rst) bslot <= 0;
    else      bslot <= (bslot + 1) % CH;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t angle=%0d)", tag, got, exp, $time, cur);
    end
  endtask

  // Target t is crossed when its forward distance from a is within the travel a->b.
  function automatic bit crossed(int a, int b, int t);
    int travel, d;
    if (t > AMAX) return 1'b0;
    travel = (b - a + N) % N;
    d      = (t - a + N) % N;
    return (d != 0) && (d <= travel);
  endfunction

  task automatic model_move(int a, int b, int w, bit wr);
    for (int c = 0; c < CH; c++) begin
      int s, r;
      bit hs, hr, use_new;
      // Channels evaluated after the wrap cycle already see the new bank.
      use_new = wr && m_pend && (c != w);
      s  = use_new ? m_sh_set[c] : m_act_set[c];
      r  = use_new ? m_sh_rst[c] : m_act_rst[c];
      hs = crossed(a, b, s);
      hr = crossed(a, b, r);
      if (hs && hr)  m_coil[c] = ((s - a + N) % N) > ((r - a + N) % N);
      else if (hs)   m_coil[c] = 1'b1;
      else if (hr)   m_coil[c] = 1'b0;
      if (!m_en[c])  m_coil[c] = 1'b0;
    end
    if (wr && m_pend) begin
      m_act_set = m_sh_set;
      m_act_rst = m_sh_rst;
      m_pend    = 1'b0;
    end
  endtask

  // Move angle to na, optionally with commit/write in that same cycle, then
  // check the coils exactly CH clocks later (the worst-case latency).
  task automatic step(input int na, input bit cm, input bit we, input int wa, input int wd);
    int a, w;
    bit wr;
    @(negedge clk);
    a  = cur;
    w  = bslot;
    wr = (na < a);
    angle      = na[AW-1:0];
    cfg_commit = cm;
    cfg_we     = we;
    cfg_addr   = wa[2:0];
    cfg_data   = wd[AW-1:0];
    model_move(a, na, w, wr);
    if (cm) m_pend = 1'b1;
    if (we) begin
      if (wa[0]) m_sh_rst[wa >> 1] = wd;
      else       m_sh_set[wa >> 1] = wd;
    end
    cur = na;
    @(negedge clk);
    cfg_commit = 1'b0;
    cfg_we     = 1'b0;
    repeat (CH - 1) @(negedge clk);
    chk("coil", coil, m_coil);
    chk("commit_pend", commit_pend, m_pend);
    chk("overrun_clear", overrun, 0);
    repeat (STEP - CH - 1) @(negedge clk);
  endtask

  task automatic cfg_wr(input int c, input int sel, input int val);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = 3'((c << 1) | sel);
    cfg_data = val[AW-1:0];
    if (sel != 0) m_sh_rst[c] = val;
    else          m_sh_set[c] = val;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_commit();
    @(negedge clk);
    cfg_commit = 1'b1;
    m_pend = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
  endtask

  task automatic step_to(input int target);
    while (cur < target) begin
      int nx;
      nx = cur + $urandom_range(1, 64);
      if (nx > target) nx = target;
      step(nx, 0, 0, 0, 0);
    end
  endtask

  // One full engine cycle up to and through the wrap. Always stops at 90
  // then jumps to 160 so the 100/150 pair on ch2 lands in one window.
  task automatic run_rev(input bit rnd);
    bit done = 1'b0;
    while (!done) begin
      int nx;
      if (cur < 90) begin
        nx = cur + $urandom_range(1, 64);
        if (nx > 90) nx = 90;
      end else if (cur == 90) begin
        nx = 160;
      end else begin
        nx = cur + $urandom_range(1, 64);
        if (nx > AMAX) begin
          nx   = nx - N;
          done = 1'b1;
        end
      end
      if (rnd) begin
        if ($urandom_range(0, 7) == 0)
          cfg_wr($urandom_range(0, CH - 1), $urandom_range(0, 1), $urandom_range(0, 8191));
        if ($urandom_range(0, 15) == 0) do_commit();
        if ($urandom_range(0, 15) == 0) begin
          int c;
          c = $urandom_range(0, CH - 1);
          @(negedge clk);
          ch_en[c] = ~ch_en[c];
          m_en[c]  = ch_en[c];
          if (!m_en[c]) m_coil[c] = 1'b0;
        end
      end
      step(nx, 0, 0, 0, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_coil", coil, 0);
    chk("rst_commit_pend", commit_pend, 0);
    chk("rst_overrun", overrun, 0);
    for (int c = 0; c < CH; c++) begin
      m_act_set[c] = 0; m_act_rst[c] = 0; m_sh_set[c] = 0; m_sh_rst[c] = 0;
    end
    m_pend = 1'b0; m_coil = '0; m_en = '1; cur = 0;
    rst = 1'b1;
    @(negedge clk);
    hwag_start = 1'b1;
    angle = '0;

    // Basic dwell, wrap-spanning dwell, same-window pair, spare channel.
    cfg_wr(0, 0, 100);  cfg_wr(0, 1, 164);
    cfg_wr(1, 0, 7650); cfg_wr(1, 1, 20);
    cfg_wr(2, 0, 100);  cfg_wr(2, 1, 150);
    cfg_wr(3, 0, 3000); cfg_wr(3, 1, 3100);
    chk("shadow_only_no_pend", commit_pend, 0);
    do_commit();
    chk("pend_after_commit", commit_pend, 1);
    run_rev(0);
    run_rev(0);

    // Shadow write without commit must not disturb the running cycle.
    step_to(3000);
    cfg_wr(0, 0, 200);
    step_to(5000);
    do_commit();
    chk("pend_until_wrap", commit_pend, 1);
    run_rev(0);
    run_rev(0);

    // Reversed same-window pair: set later than reset, coil ends high.
    cfg_wr(2, 0, 150); cfg_wr(2, 1, 100);
    do_commit();
    run_rev(0);
    run_rev(0);

    // Commit in a wrap cycle with nothing pending only arms the next wrap.
    step_to(7600);
    step(10, 1, 0, 0, 0);
    // Pending commit plus new commit plus shadow write in the transfer cycle.
    step_to(7600);
    step(5, 1, 1, 6, 1234);
    run_rev(0);

    // Drop hwag_start mid-dwell, skip past ch1's set angle while low.
    step_to(7600);
    @(negedge clk);
    hwag_start = 1'b0;
    @(negedge clk);
    chk("start_drop_coil", coil, 0);
    angle = 13'd7660;
    @(negedge clk);
    angle = 13'd7675;
    @(negedge clk);
    hwag_start = 1'b1;
    m_coil = '0;
    cur = 7675;
    repeat (CH + 1) @(negedge clk);
    chk("start_raise_no_burst", coil, 0);
    run_rev(0);
    run_rev(0);

    repeat (3) run_rev(1);

    // Angle moving every 2 clocks is faster than one scan round.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cur = (cur + 1) % N;
      angle = cur[AW-1:0];
      @(negedge clk);
    end
    @(negedge clk);
    chk("overrun_set", overrun, 1);
    repeat (40) @(negedge clk);
    chk("overrun_sticky", overrun, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("overrun_rst", overrun, 0);
    chk("rst2_coil", coil, 0);
    chk("rst2_commit_pend", commit_pend, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/hwag_coil_sched.md
# hwag_coil_sched

Angle-domain scheduler for ignition coil outputs, driven by the angle counter of `hwag`. It holds a dwell-start (set) and spark (reset) angle per channel and drives each coil output high and low as the engine angle crosses those values. Channels are evaluated round-robin, one per clock. Angle updates are tens of clocks apart, so every channel is visited between updates. Configuration is double-buffered and takes effect only at the cycle wrap (angle → 0), so a coil never sees a half-updated pair.

## Interface
Parameters:
- `CH`, 4, number of coil channels (power of two, 2..8)
- `AW`, 13, angle width
- `ANGLE_MAX`, 7679, last angle value before wrap (60-tooth wheel × 64 sub-ticks × 2 revs − 1)

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active-low
- `hwag_start`  in  1  high while `angle` is valid (hwag synchronised to wheel and cam)
- `angle`  in  AW  current engine angle, 0..ANGLE_MAX, non-decreasing except at wrap to 0
- `ch_en`  in  CH  per-channel enable
- `cfg_we`  in  1  write strobe into the shadow bank
- `cfg_addr`  in  $clog2(CH)+1  {channel, sel}; sel 0 = set angle, sel 1 = reset angle
- `cfg_data`  in  AW  angle value; values > ANGLE_MAX are written unchanged and never match
- `cfg_commit`  in  1  request shadow→active transfer at the next wrap
- `commit_pend`  out  1  transfer requested, not yet done
- `coil`  out  CH  coil drive, registered
- `overrun`  out  1  sticky; `angle` changed twice within one scan round

## Operation
- Per channel, registers `act_set`, `act_rst`, `sh_set`, `sh_rst`, `last` (all AW bits). Also a scan slot counter `slot` (0..CH-1), the previous global angle `ang_q`, and a change-tracking flag.
- `slot` increments every clock and wraps at CH-1.
- Window test, for target t and channel slot s:
  - no wrap (`angle` ≥ `last[s]`): `last[s]` < t ≤ `angle`
  - wrap: t > `last[s]` or t ≤ `angle`
  - `angle` == `last[s]`: the window is empty.
- Evaluation of slot s each clock:
  - If only the set hits, `coil[s]` ← 1.
  - If only the reset hits, `coil[s]` ← 0.
  - If both hit, the event angularly later in the window wins. Equal set/reset angles resolve to 0.
  - Then `last[s]` ← `angle`.
- `ch_en[s]` = 0 forces `coil[s]` = 0 on the next edge. `last[s]` is still updated. Re-enabling does not replay past events.
- `hwag_start` = 0 forces all `coil` to 0 and loads every `last` with `angle`. No burst of events occurs on start.
- Config writes:
  - `cfg_we` writes the shadow bank only, on the next edge.
  - `cfg_commit` sets `commit_pend`.
- Wrap detection: `angle` < `ang_q` while `hwag_start` = 1.
  - On a wrap with `commit_pend` = 1, active ← shadow for all channels and `commit_pend` ← 0 on that edge.
  - The slot evaluated in the wrap cycle uses the old active values.
- Simultaneous events:
  - `cfg_commit` in a wrap cycle sets `commit_pend`. The transfer waits for the next wrap.
  - `cfg_we` in the transfer cycle writes the shadow, and the old shadow value is what gets transferred.
- Overrun: set when `angle` changes again before the current slot returns to the slot that was active at the previous change. Cleared only by reset.

## Timing
- Reset state (`rst` = 0 at an edge): `coil` = 0, `commit_pend` = 0, `overrun` = 0, `slot` = 0; all angle registers and `ang_q` = 0.
- An event is reflected on `coil[s]` at most CH clocks after `angle` crosses the target. Within that bound it appears 1 clock after slot s is evaluated.
- The commit transfer takes 1 clock from the wrap cycle. The first slot evaluated after it uses the new angles.
- No handshake back-pressure: `cfg_we` and `cfg_commit` are accepted every clock.

## Structure
- Package `hwag_pkg` holds:
  - `AW` and `ANGLE_MAX` localparams
  - `typedef logic [AW-1:0] angle_t`
  - function `angle_in_window(last, cur, t)`, implementing the wrap rule above.
- Sub-module `hwag_coil_cfg_bank` holds the shadow/active register pairs, write decode and commit transfer. The scheduler top holds the slot counter, window evaluation, `last` registers and outputs.
- Target size is about 200 lines of RTL.

## Test plan
- Reset, then `hwag_start` = 1 with `angle` stepping +1 every 32 clocks. Program ch0 set = 100, reset = 164, commit, pass one wrap. Expected: `coil[0]` rises within 4 clocks of `angle` = 100 and falls within 4 clocks of `angle` = 164, once per cycle.
- Wrap-spanning dwell on ch1: set = 7650, reset = 20. Expected: `coil[1]` is high across 7679→0 and low after 20.
- Config guard: write ch0 set = 200 mid-cycle without commit. Expected: behaviour unchanged. After commit, the change applies only after the next wrap, with `commit_pend` high until then.
- Same-window hit: step `angle` by 70 in one update with ch2 set = 100, reset = 150. Expected: `coil[2]` ends 0. With set = 150, reset = 100 it ends 1.
- Drop and re-raise `hwag_start` mid-dwell. Expected: all `coil` = 0 on the next edge, and no events fire for angles passed while it was low.
- Step `angle` every 2 clocks with CH = 4. Expected: `overrun` = 1 and stays set until `rst` = 0.
